// File: rtl/rr_arb4x8.sv
// rr_arb4x8: round-robin 4-channel byte arbiter into a one-entry valid/ready output slot; ports CLK RESETN V READY S D O O_VALID O_READY, plus LOCK when RR_ARB4X8_LOCK_EN is defined
module rr_arb4x8 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [3:0]       V,
  output logic [3:0]       READY,
  output logic [1:0]       S,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
`ifdef RR_ARB4X8_LOCK_EN
  input  logic [3:0]       LOCK,
`endif
  input  logic             O_READY
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic [1:0] last, pick;
  logic hit, lock_hit, free, grant;
  assign O_VALID = state == FULL;
  assign free = !O_VALID || O_READY;
  always_comb begin
    pick = last;
    hit = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      if (V[last + 2'(i)]) begin
        pick = last + 2'(i);
        hit = 1'b1;
      end
    end
`ifdef RR_ARB4X8_LOCK_EN
    lock_hit = V[last] && LOCK[last];
`else
    lock_hit = 1'b0;
`endif
    pick = lock_hit ? last : pick;
    grant = RESETN && free && hit;
    S = grant ? pick : last;
    READY = grant ? 4'b0001 << pick : 4'b0000;
    state_nxt = free ? (hit ? FULL : EMPTY) : state;
  end
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state <= EMPTY;
      O <= '0;
      last <= 2'd3;
    end else begin
      state <= state_nxt;
      if (grant) begin
        O <= D;
        last <= pick;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb4x8.sv
// tb_rr_arb4x8: directed table-driven bench for rr_arb4x8
module tb_rr_arb4x8;
  logic CLK = 1'b0;
  logic RESETN;
  logic [3:0] V;
  logic [3:0] READY;
  logic [1:0] S;
  logic [7:0] D;
  logic [7:0] O;
  logic O_VALID;
  logic O_READY;
  logic [7:0] chan [4];
`ifdef RR_ARB4X8_LOCK_EN
  logic [3:0] LOCK = 4'h0;
`endif
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic       rstn;
    logic [3:0] v;
    logic       ordy;
    logic [3:0] ready;
    logic [1:0] s;
    logic       ov;
    logic [7:0] o;
  } vec_t;
  vec_t tbl [19];
  always #5 CLK = ~CLK;
  assign D = chan[S];
  rr_arb4x8 #(.WIDTH(8)) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .V(V),
    .READY(READY),
    .S(S),
    .D(D),
    .O(O),
    .O_VALID(O_VALID),
`ifdef RR_ARB4X8_LOCK_EN
    .LOCK(LOCK),
`endif
    .O_READY(O_READY)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  initial begin
    chan[0] = 8'hA0;
    chan[1] = 8'hA1;
    chan[2] = 8'hA2;
    chan[3] = 8'hA3;
    RESETN = 1'b0;
    V = 4'h0;
    O_READY = 1'b0;
    tbl[0]  = '{1'b0, 4'hF, 1'b0, 4'b0000, 2'd3, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 4'hF, 1'b0, 4'b0000, 2'd3, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, 8'hA0};
    tbl[4]  = '{1'b1, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA1};
    tbl[5]  = '{1'b1, 4'hF, 1'b1, 4'b1000, 2'd3, 1'b1, 8'hA2};
    tbl[6]  = '{1'b1, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, 8'hA3};
    tbl[7]  = '{1'b1, 4'h4, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA0};
    tbl[8]  = '{1'b1, 4'h4, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA2};
    tbl[9]  = '{1'b1, 4'h4, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA2};
    tbl[10] = '{1'b1, 4'h4, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA2};
    tbl[11] = '{1'b1, 4'h4, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA2};
    tbl[12] = '{1'b1, 4'h2, 1'b1, 4'b0010, 2'd1, 1'b1, 8'hA2};
    tbl[13] = '{1'b1, 4'hF, 1'b0, 4'b0000, 2'd1, 1'b1, 8'hA1};
    tbl[14] = '{1'b1, 4'hF, 1'b0, 4'b0000, 2'd1, 1'b1, 8'hA1};
    tbl[15] = '{1'b1, 4'hF, 1'b0, 4'b0000, 2'd1, 1'b1, 8'hA1};
    tbl[16] = '{1'b1, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA1};
    tbl[17] = '{1'b1, 4'h0, 1'b1, 4'b0000, 2'd2, 1'b1, 8'hA2};
    tbl[18] = '{1'b1, 4'h0, 1'b0, 4'b0000, 2'd2, 1'b0, 8'hA2};
    for (int i = 0; i < 19; i++) begin
      @(negedge CLK);
      RESETN = tbl[i].rstn;
      V = tbl[i].v;
      O_READY = tbl[i].ordy;
      #1;
      check($sformatf("row%0d READY", i), 32'(READY), 32'(tbl[i].ready));
      check($sformatf("row%0d S", i), 32'(S), 32'(tbl[i].s));
      check($sformatf("row%0d O_VALID", i), 32'(O_VALID), 32'(tbl[i].ov));
      check($sformatf("row%0d O", i), 32'(O), 32'(tbl[i].o));
    end
    @(negedge CLK);
    chan[3] = 8'h5A;
    V = 4'b1000;
    O_READY = 1'b1;
    #1;
    check("load5a READY", 32'(READY), 32'h8);
    @(negedge CLK);
    RESETN = 1'b0;
    V = 4'hF;
    O_READY = 1'b0;
    #1;
    check("rst READY", 32'(READY), 32'h0);
    check("rst pre O", 32'(O), 32'h5A);
    check("rst pre O_VALID", 32'(O_VALID), 32'h1);
    @(posedge CLK);
    #1;
    check("rst post O_VALID", 32'(O_VALID), 32'h0);
    check("rst post O", 32'(O), 32'h0);
    @(negedge CLK);
    RESETN = 1'b1;
    V = 4'b1000;
    O_READY = 1'b1;
    #1;
    check("rel READY", 32'(READY), 32'h8);
    check("rel S", 32'(S), 32'h3);
    @(posedge CLK);
    #1;
    check("rel O", 32'(O), 32'h5A);
    check("rel O_VALID", 32'(O_VALID), 32'h1);
    @(negedge CLK);
    V = 4'hF;
    #1;
    check("wrap READY", 32'(READY), 32'h1);
`ifdef RR_ARB4X8_LOCK_EN
    @(negedge CLK);
    #1;
    check("lock g1 READY", 32'(READY), 32'h2);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      LOCK = 4'b0010;
      #1;
      check($sformatf("lock hold%0d READY", i), 32'(READY), 32'h2);
    end
    @(negedge CLK);
    LOCK = 4'b0000;
    #1;
    check("lock break READY", 32'(READY), 32'h4);
`endif
    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
